etherneco_synctimer_slave_parser: RTL and testbench

- Byte-stream parser/forwarder on the EtherNeco ring for a sync-timer slave node.
- Receives sync frames, extracts the master timestamp and drives the correct_* inputs of the slave's sync-timer core.
- Writes this node's local receive timestamp into its own response slot and forwards the frame downstream with 1-cycle latency.
- Generalises the slave with configurable timer width, slot width, node addressing, override mode and frame error detection.

---
 rtl/etherneco_synctimer_slave_parser.sv | 248 ++++++++++++++++++++++++
 tb/tb_etherneco_synctimer_slave_parser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/etherneco_synctimer_slave_parser.sv
// EtherNeco sync-timer slave parser: forwards the ring byte stream with 1-cycle latency, extracts the master time
// and stamps the local receive time into this node's slot. Optional macro ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN.
module etherneco_synctimer_slave_parser #(
  parameter int unsigned            TIMER_WIDTH   = 64,
  parameter int unsigned            SLOT_BYTES    = 4,
  parameter int unsigned            NODE_ID_WIDTH = 8,
  parameter logic [TIMER_WIDTH-1:0] TIME_OFFSET   = '0,
  parameter logic [7:0]             CMD_SYNC      = 8'h01,
  parameter int unsigned            CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NODE_ID_WIDTH-1:0] node_id,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  input  logic                     s_last,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     m_last,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  output logic                     correct_override,
  output logic [TIMER_WIDTH-1:0]   correct_time,
  output logic                     correct_valid,
  output logic                     frame_error,
  output logic [CNT_WIDTH-1:0]     sync_count
);

  localparam int unsigned TB = TIMER_WIDTH / 8;
  localparam int unsigned SW = ((NODE_ID_WIDTH + 4 > CNT_WIDTH) ? NODE_ID_WIDTH + 4 : CNT_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_TIME, S_BODY, S_DROP} state_e;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TIMER_WIDTH-1:0]   time_q, time_d;
  logic [TIMER_WIDTH-1:0]   rx_time_q, rx_time_d;
  logic                     ovr_q, ovr_d;
  logic [NODE_ID_WIDTH-1:0] node_q, node_d;
  logic                     m_last_q, m_last_d;
  logic [7:0]               m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     cor_ovr_q, cor_ovr_d;
  logic [TIMER_WIDTH-1:0]   cor_time_q, cor_time_d;
  logic                     cor_valid_q, cor_valid_d;
  logic                     ferr_q, ferr_d;
  logic [CNT_WIDTH-1:0]     sync_cnt_q, sync_cnt_d;

  logic                     is_sync_c;
  logic                     done_c;
  logic [TIMER_WIDTH-1:0]   shift_c;
  logic [TIMER_WIDTH-1:0]   master_c;
  logic [SW-1:0]            pos_c, slot_start_c, off_c;
  logic                     in_slot_c;
  logic [7:0]               slot_byte_c;

`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
  localparam int unsigned NUMERATOR   = 10;
  localparam int unsigned DENOMINATOR = 3;
  localparam int unsigned PW          = CNT_WIDTH + 32;

  logic [CNT_WIDTH-1:0]   lat_q, lat_d;
  logic [CNT_WIDTH-1:0]   latc_q, latc_d;
  logic                   pend_q, pend_d;
  logic                   pend_ovr_q, pend_ovr_d;
  logic [TIMER_WIDTH-1:0] sum_q, sum_d;
  logic [PW-1:0]          prod_c;
  logic [TIMER_WIDTH-1:0] comp_c;
`endif

  // Frame decode helpers: sync match, time shift-in and slot window
  always_comb begin
    is_sync_c    = enable && (s_data[6:0] == CMD_SYNC[6:0]);
    shift_c      = (time_q >> 8) | (TIMER_WIDTH'(s_data) << (TIMER_WIDTH - 8));
    master_c     = (state_q == S_TIME) ? shift_c : time_q;
    pos_c        = SW'(byte_cnt_q);
    slot_start_c = SW'(1 + TB) + SW'(node_q) * SW'(SLOT_BYTES);
    off_c        = pos_c - slot_start_c;
    in_slot_c    = (byte_cnt_q != '1) && (pos_c >= slot_start_c) &&
                   (pos_c < slot_start_c + SW'(SLOT_BYTES));
    slot_byte_c  = 8'(rx_time_q >> {off_c, 3'b000});
  end

  // Next-state, forwarding and correction logic
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    time_d      = time_q;
    rx_time_d   = rx_time_q;
    ovr_d       = ovr_q;
    node_d      = node_q;
    m_valid_d   = s_valid;
    m_last_d    = s_last;
    m_data_d    = s_data;
    cor_valid_d = 1'b0;
    cor_time_d  = cor_time_q;
    cor_ovr_d   = cor_ovr_q;
    ferr_d      = 1'b0;
    sync_cnt_d  = sync_cnt_q;
    done_c      = 1'b0;
`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
    lat_d       = lat_q;
    latc_d      = latc_q;
    pend_d      = 1'b0;
    pend_ovr_d  = pend_ovr_q;
    sum_d       = sum_q;
    if (state_q != S_IDLE && lat_q != '1) lat_d = lat_q + CNT_WIDTH'(1);
`endif

    if (s_valid) begin
      if (s_last)                 byte_cnt_d = '0;
      else if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);

      unique case (state_q)
        S_IDLE: begin
          if (is_sync_c) begin
            rx_time_d = current_time;
            ovr_d     = s_data[7];
            node_d    = node_id;
            time_d    = '0;
`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
            lat_d     = CNT_WIDTH'(1);
`endif
            if (s_last) ferr_d  = 1'b1;
            else        state_d = S_TIME;
          end else if (!s_last) begin
            state_d = S_DROP;
          end
        end
        S_TIME: begin
          time_d = shift_c;
          if (byte_cnt_q == CNT_WIDTH'(TB)) begin
            // A frame ending right after the time field still carries a full master time
            if (s_last) begin
              done_c  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_BODY;
            end
          end else if (s_last) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BODY: begin
          if (in_slot_c) m_data_d = slot_byte_c;
          if (s_last) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (s_last) state_d = S_IDLE;
        end
      endcase
    end

`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
    // Stage 1 captures the sum and latency; stage 2 adds the scaled latency
    if (done_c) begin
      pend_d     = 1'b1;
      pend_ovr_d = ovr_q;
      sum_d      = master_c + TIME_OFFSET;
      latc_d     = lat_q;
    end
    if (pend_q) begin
      cor_valid_d = 1'b1;
      cor_time_d  = sum_q + comp_c;
      cor_ovr_d   = pend_ovr_q;
      sync_cnt_d  = sync_cnt_q + CNT_WIDTH'(1);
    end
`else
    if (done_c) begin
      cor_valid_d = 1'b1;
      cor_time_d  = master_c + TIME_OFFSET;
      cor_ovr_d   = ovr_q;
      sync_cnt_d  = sync_cnt_q + CNT_WIDTH'(1);
    end
`endif
  end

`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
  always_comb begin
    prod_c = PW'(latc_q) * PW'(NUMERATOR);
    comp_c = TIMER_WIDTH'(prod_c / PW'(DENOMINATOR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_q      <= '0;
      latc_q     <= '0;
      pend_q     <= 1'b0;
      pend_ovr_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      lat_q      <= lat_d;
      latc_q     <= latc_d;
      pend_q     <= pend_d;
      pend_ovr_q <= pend_ovr_d;
      sum_q      <= sum_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      time_q      <= '0;
      rx_time_q   <= '0;
      ovr_q       <= 1'b0;
      node_q      <= '0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      cor_ovr_q   <= 1'b0;
      cor_time_q  <= '0;
      cor_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      sync_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      time_q      <= time_d;
      rx_time_q   <= rx_time_d;
      ovr_q       <= ovr_d;
      node_q      <= node_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      cor_ovr_q   <= cor_ovr_d;
      cor_time_q  <= cor_time_d;
      cor_valid_q <= cor_valid_d;
      ferr_q      <= ferr_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  assign m_last           = m_last_q;
  assign m_data           = m_data_q;
  assign m_valid          = m_valid_q;
  assign correct_override = cor_ovr_q;
  assign correct_time     = cor_time_q;
  assign correct_valid    = cor_valid_q;
  assign frame_error      = ferr_q;
  assign sync_count       = sync_cnt_q;

endmodule

// File: tb/tb_etherneco_synctimer_slave_parser.sv
// Randomized frame-level bench for etherneco_synctimer_slave_parser: each frame's expected output stream,
// strobes and correction are derived from the frame layout rules and compared to what the DUT emitted.
module tb_etherneco_synctimer_slave_parser;

  localparam int unsigned TB   = 8;
  localparam int unsigned SLOT = 4;
  localparam logic [63:0] OFS  = 64'h0000_0000_0000_0123;
`ifdef ETHERNECO_SYNCTIMER_SLAVE_DELAY_COMP_EN
  localparam int          LAT   = 1;
  localparam bit          DCOMP = 1'b1;
`else
  localparam int          LAT   = 0;
  localparam bit          DCOMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  node_id = '0;
  logic [63:0] current_time = '0;
  logic        s_last = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_last, m_valid, correct_override, correct_valid, frame_error;
  logic [7:0]  m_data;
  logic [63:0] correct_time;
  logic [15:0] sync_count;

  etherneco_synctimer_slave_parser #(.TIME_OFFSET(OFS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .node_id(node_id), .current_time(current_time),
    .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
    .m_last(m_last), .m_data(m_data), .m_valid(m_valid),
    .correct_override(correct_override), .correct_time(correct_time), .correct_valid(correct_valid),
    .frame_error(frame_error), .sync_count(sync_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  logic [7:0]  outq[$];
  int          mlast_n = 0, mlast_pos = 0, mlast_cyc = 0;
  int          cv_n = 0, cv_cyc = 0, ferr_n = 0;
  logic [63:0] cv_time = '0;
  logic        cv_ovr = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      outq.push_back(m_data);
      if (m_last) begin
        mlast_n   <= mlast_n + 1;
        mlast_pos <= outq.size() - 1;
        mlast_cyc <= cyc;
      end
    end
    if (correct_valid) begin
      cv_n    <= cv_n + 1;
      cv_cyc  <= cyc;
      cv_time <= correct_time;
      cv_ovr  <= correct_override;
    end
    if (frame_error) ferr_n <= ferr_n + 1;
  end

  int          n_vec = 0, n_err = 0;
  logic [63:0] exp_time = '0;
  logic        exp_ovr = 1'b0;
  int          exp_scnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input bit en, input int nid,
                           input logic [63:0] ctime, input int gapmax);
    int          n, base, cvb, feb, mlb, cyc_cmd, cyc_last, start;
    bit          sync, err, corr;
    logic [63:0] master, comp;
    logic [7:0]  expb, cmd;
    n = fr.size(); base = outq.size(); cvb = cv_n; feb = ferr_n; mlb = mlast_n;
    cyc_cmd = 0; cyc_last = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
        @(posedge clk); #1;
      end
      if (i == 0) begin
        enable = en; node_id = 8'(nid); current_time = ctime;
      end else begin
        enable = 1'($urandom); node_id = 8'($urandom); current_time = {$urandom, $urandom};
      end
      s_valid = 1'b1; s_data = fr[i]; s_last = (i == n - 1);
      @(posedge clk); #1;
      if (i == 0)     cyc_cmd  = cyc;
      if (i == n - 1) cyc_last = cyc;
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reference: frame layout rules applied to the whole frame
    cmd    = fr[0];
    sync   = en && (cmd[6:0] == 7'h01);
    err    = sync && (n <= TB);
    corr   = sync && (n > TB);
    master = '0;
    start  = 1 + TB + nid * SLOT;
    if (corr) for (int i = 0; i < TB; i++) master[8*i +: 8] = fr[1+i];

    chk("nbytes", 64'(outq.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      expb = fr[i];
      if (corr && i >= start && i < start + SLOT) expb = ctime[8*(i-start) +: 8];
      if (base + i < outq.size()) chk("byte", 64'(outq[base+i]), 64'(expb));
    end
    chk("mlast_n", 64'(mlast_n - mlb), 64'd1);
    chk("mlast_pos", 64'(mlast_pos - base), 64'(n - 1));
    chk("ferr", 64'(ferr_n - feb), 64'(err));
    chk("cvalid", 64'(cv_n - cvb), 64'(corr));
    if (corr) begin
      comp     = DCOMP ? 64'((cyc_last - cyc_cmd) * 10 / 3) : 64'd0;
      exp_time = master + OFS + comp;
      exp_ovr  = cmd[7];
      exp_scnt++;
      chk("cv_lat", 64'(cv_cyc - mlast_cyc), 64'(LAT));
      chk("cv_time", cv_time, exp_time);
      chk("cv_ovr", 64'(cv_ovr), 64'(exp_ovr));
    end
    chk("ctime_hold", correct_time, exp_time);
    chk("covr_hold", 64'(correct_override), 64'(exp_ovr));
    chk("scnt", 64'(sync_count), 64'(exp_scnt & 16'hFFFF));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] cmd;
    int         n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_cvalid", 64'(correct_valid), 64'd0);
    chk("rst_ctime", correct_time, 64'd0);
    chk("rst_scnt", 64'(sync_count), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Sync frame, node 0, master time 0x1000, local time 0x500
    fr.delete(); fr.push_back(8'h01); fr.push_back(8'h00); fr.push_back(8'h10);
    repeat (10) fr.push_back(8'h00);
    run_frame(fr, 1'b1, 0, 64'h500, 0);

    // Override sync frame for node 2, 21 bytes
    fr.delete(); fr.push_back(8'h81);
    repeat (20) fr.push_back(8'($urandom));
    run_frame(fr, 1'b1, 2, {$urandom, $urandom}, 1);

    // Short sync frame
    fr.delete(); fr.push_back(8'h01);
    repeat (3) fr.push_back(8'($urandom));
    run_frame(fr, 1'b1, 0, {$urandom, $urandom}, 0);

    // Non-sync command, then sync command with enable low
    fr.delete(); fr.push_back(8'h02);
    repeat (16) fr.push_back(8'($urandom));
    run_frame(fr, 1'b1, 0, {$urandom, $urandom}, 1);
    fr[0] = 8'h01;
    run_frame(fr, 1'b0, 0, {$urandom, $urandom}, 1);

    // Reset in the middle of a sync frame
    enable = 1'b1; node_id = 8'd0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_last = 1'b0; s_data = 8'($urandom);
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1 chk("midrst_mvalid", 64'(m_valid), 64'd0);
    chk("midrst_scnt", 64'(sync_count), 64'd0);
    s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_hold", 64'(m_valid), 64'd0);
    end
    reset = 1'b1;
    exp_scnt = 0; exp_time = '0; exp_ovr = 1'b0;
    @(posedge clk); #1;
    fr.delete(); fr.push_back(8'h01);
    repeat (12) fr.push_back(8'($urandom));
    run_frame(fr, 1'b1, 0, {$urandom, $urandom}, 0);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) != 0)   cmd[6:0] = 7'h01;
      else if (cmd[6:0] == 7'h01)      cmd[6:0] = 7'h02;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(10, 35));
      fr.delete(); fr.push_back(cmd);
      for (int i = 1; i < n; i++) fr.push_back(8'($urandom));
      run_frame(fr, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)),
                {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
